// File: rtl/fat32_bpb_parser_if.sv
// Sector-read handshake between the FAT32 BPB parser (master) and the SD-card
// sector reader (slave): one-cycle read request plus a byte stream qualified by dataValid.
interface fat32_bpb_parser_if;
    logic        readRequest;
    logic [31:0] readSector;
    logic        dataValid;
    logic [7:0]  dataByte;

    modport master (output readRequest, output readSector, input dataValid, input dataByte);
    modport slave  (input readRequest, input readSector, output dataValid, output dataByte);
endinterface

// File: rtl/fat32_bpb_parser.sv
// FAT32 boot-sector (BPB) parser: requests the boot sector, captures the geometry fields
// little-endian, validates them and publishes them. Optional macro FAT32_MBR_FOLLOW_EN.
module fat32_bpb_parser #(
    parameter int unsigned SECTOR_BYTES = 512,
    parameter logic [31:0] BOOT_LBA     = 32'd0
) (
    input  logic                      updateClock,
    input  logic                      rstn,
    input  logic                      start,
    fat32_bpb_parser_if.master        bus,
    output logic [15:0]               ReservedSectors,
    output logic [7:0]                SectorsPerCluster,
    output logic [8:0]                NumberOfFAT,
    output logic [31:0]               theLengthOfFAT,
    output logic [31:0]               RootCluster,
    output logic [31:0]               partitionStart,
    output logic                      busy,
    output logic                      bpbValid,
    output logic                      bpbError,
    output logic [2:0]                errorCode
);

    localparam logic [15:0] BPS_REQ = 16'(SECTOR_BYTES);

    typedef enum logic [2:0] {IDLE, REQ, RECV, CHECK, DONE, ERR} state_t;

    state_t      state, stateNext;
    logic [8:0]  cnt;
    logic [31:0] readSector;

    logic [7:0]  shJump, shSig0, shSig1, shSpc, shFats;
    logic [15:0] shBps, shRsvd;
    logic [31:0] shFatSz, shRoot;
`ifdef FAT32_MBR_FOLLOW_EN
    logic [31:0] shMbrLba;
    logic        redirected;
`endif

    logic [2:0]  chkCode;
    logic        chkRedirect;

    // Validation verdict for the captured sector, in priority order
    always_comb begin
        chkCode     = 3'd0;
        chkRedirect = 1'b0;
        if (!(shSig0 == 8'h55 && shSig1 == 8'hAA)) begin
            chkCode = 3'd1;
        end else if (!(shJump == 8'hEB || shJump == 8'hE9)) begin
`ifdef FAT32_MBR_FOLLOW_EN
            if (!redirected && shMbrLba != 32'd0) chkRedirect = 1'b1;
            else                                   chkCode     = 3'd4;
`else
            chkCode = 3'd4;
`endif
        end else if (shBps != BPS_REQ) begin
            chkCode = 3'd2;
        end else if (shFats == 8'd0 || shSpc == 8'd0) begin
            chkCode = 3'd3;
        end
    end

    always_ff @(posedge updateClock) begin
        if (!rstn) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext       = state;
        bus.readRequest = 1'b0;
        busy            = 1'b0;
        bpbValid        = 1'b0;
        bpbError        = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                bpbValid = (state == DONE);
                bpbError = (state == ERR);
                if (start) stateNext = REQ;
            end
            REQ: begin
                bus.readRequest = 1'b1;
                busy            = 1'b1;
                stateNext       = RECV;
            end
            RECV: begin
                busy = 1'b1;
                if (bus.dataValid && cnt == 9'd511) stateNext = CHECK;
            end
            CHECK: begin
                busy = 1'b1;
                if (chkRedirect)          stateNext = REQ;
                else if (chkCode != 3'd0) stateNext = ERR;
                else                      stateNext = DONE;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign bus.readSector = readSector;

    always_ff @(posedge updateClock) begin
        if (!rstn) begin
            cnt               <= 9'd0;
            readSector        <= 32'd0;
            errorCode         <= 3'd0;
            shJump            <= 8'd0;
            shSig0            <= 8'd0;
            shSig1            <= 8'd0;
            shSpc             <= 8'd0;
            shFats            <= 8'd0;
            shBps             <= 16'd0;
            shRsvd            <= 16'd0;
            shFatSz           <= 32'd0;
            shRoot            <= 32'd0;
            ReservedSectors   <= 16'd0;
            SectorsPerCluster <= 8'd0;
            NumberOfFAT       <= 9'd0;
            theLengthOfFAT    <= 32'd0;
            RootCluster       <= 32'd0;
            partitionStart    <= 32'd0;
`ifdef FAT32_MBR_FOLLOW_EN
            shMbrLba          <= 32'd0;
            redirected        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        readSector <= BOOT_LBA;
                        errorCode  <= 3'd0;
`ifdef FAT32_MBR_FOLLOW_EN
                        redirected <= 1'b0;
`endif
                    end
                end
                REQ: cnt <= 9'd0;
                RECV: begin
                    if (bus.dataValid) begin
                        cnt <= cnt + 9'd1;
                        // Little-endian capture by absolute sector offset
                        case (cnt)
                            9'h000: shJump        <= bus.dataByte;
                            9'h00B: shBps[7:0]    <= bus.dataByte;
                            9'h00C: shBps[15:8]   <= bus.dataByte;
                            9'h00D: shSpc         <= bus.dataByte;
                            9'h00E: shRsvd[7:0]   <= bus.dataByte;
                            9'h00F: shRsvd[15:8]  <= bus.dataByte;
                            9'h010: shFats        <= bus.dataByte;
                            9'h024: shFatSz[7:0]   <= bus.dataByte;
                            9'h025: shFatSz[15:8]  <= bus.dataByte;
                            9'h026: shFatSz[23:16] <= bus.dataByte;
                            9'h027: shFatSz[31:24] <= bus.dataByte;
                            9'h02C: shRoot[7:0]    <= bus.dataByte;
                            9'h02D: shRoot[15:8]   <= bus.dataByte;
                            9'h02E: shRoot[23:16]  <= bus.dataByte;
                            9'h02F: shRoot[31:24]  <= bus.dataByte;
`ifdef FAT32_MBR_FOLLOW_EN
                            9'h1C6: shMbrLba[7:0]   <= bus.dataByte;
                            9'h1C7: shMbrLba[15:8]  <= bus.dataByte;
                            9'h1C8: shMbrLba[23:16] <= bus.dataByte;
                            9'h1C9: shMbrLba[31:24] <= bus.dataByte;
`endif
                            9'h1FE: shSig0 <= bus.dataByte;
                            9'h1FF: shSig1 <= bus.dataByte;
                            default: ;
                        endcase
                    end
                end
                CHECK: begin
                    if (chkRedirect) begin
`ifdef FAT32_MBR_FOLLOW_EN
                        readSector <= shMbrLba;
                        redirected <= 1'b1;
`endif
                    end else if (chkCode != 3'd0) begin
                        errorCode <= chkCode;
                    end else begin
                        ReservedSectors   <= shRsvd;
                        SectorsPerCluster <= shSpc;
                        NumberOfFAT       <= {1'b0, shFats};
                        theLengthOfFAT    <= shFatSz;
                        RootCluster       <= shRoot;
                        partitionStart    <= readSector;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fat32_bpb_parser.sv
// Bench for fat32_bpb_parser: directed sectors, a sector-level model of the expected
// outcome, and a per-cycle comparison of every output against that model.
module tb_fat32_bpb_parser;

    logic updateClock = 1'b0;
    always #5 updateClock = ~updateClock;

    logic        rstn, start;
    logic [15:0] ReservedSectors;
    logic [7:0]  SectorsPerCluster;
    logic [8:0]  NumberOfFAT;
    logic [31:0] theLengthOfFAT, RootCluster, partitionStart;
    logic        busy, bpbValid, bpbError;
    logic [2:0]  errorCode;

    fat32_bpb_parser_if bus();

    fat32_bpb_parser #(.SECTOR_BYTES(512), .BOOT_LBA(32'd0)) dut (
        .updateClock(updateClock), .rstn(rstn), .start(start), .bus(bus),
        .ReservedSectors(ReservedSectors), .SectorsPerCluster(SectorsPerCluster),
        .NumberOfFAT(NumberOfFAT), .theLengthOfFAT(theLengthOfFAT),
        .RootCluster(RootCluster), .partitionStart(partitionStart),
        .busy(busy), .bpbValid(bpbValid), .bpbError(bpbError), .errorCode(errorCode));

    logic [7:0]  sec  [512];
    logic [7:0]  sec2 [512];

    int vectors = 0, miscompares = 0, reqPulses = 0;
    bit cmpEn = 1'b0;

    logic        eBusy, eReq, eValid, eErr;
    logic [2:0]  eCode;
    logic [31:0] eSector, eRsvd, eSpc, eFats, eFatSz, eRoot, ePstart;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("busy", 32'(busy), 32'(eBusy));
        chk("readRequest", 32'(bus.readRequest), 32'(eReq));
        chk("bpbValid", 32'(bpbValid), 32'(eValid));
        chk("bpbError", 32'(bpbError), 32'(eErr));
        chk("errorCode", 32'(errorCode), 32'(eCode));
        chk("readSector", bus.readSector, eSector);
        chk("ReservedSectors", 32'(ReservedSectors), eRsvd);
        chk("SectorsPerCluster", 32'(SectorsPerCluster), eSpc);
        chk("NumberOfFAT", 32'(NumberOfFAT), eFats);
        chk("theLengthOfFAT", theLengthOfFAT, eFatSz);
        chk("RootCluster", RootCluster, eRoot);
        chk("partitionStart", partitionStart, ePstart);
    endtask

    task automatic zero_exp();
        eBusy = 0; eReq = 0; eValid = 0; eErr = 0; eCode = 0; eSector = 0;
        eRsvd = 0; eSpc = 0; eFats = 0; eFatSz = 0; eRoot = 0; ePstart = 0;
    endtask

    function automatic logic [31:0] le(input logic [7:0] s [512], input int off, input int n);
        logic [31:0] v = 0;
        for (int k = 0; k < n; k++) v = v + (32'(s[off+k]) << (8*k));
        return v;
    endfunction

    // Outcome of parsing one sector, straight from the field rules
    function automatic void model(input logic [7:0] s [512], input bit allowRedir,
                                  output int code, output bit redir, output logic [31:0] lba);
        bit sigOk  = (s[510] == 8'h55) && (s[511] == 8'hAA);
        bit isBoot = (s[0] == 8'hEB) || (s[0] == 8'hE9);
        code  = 0;
        redir = 0;
        lba   = le(s, 'h1C6, 4);
        if (!sigOk) code = 1;
        else if (!isBoot) begin
`ifdef FAT32_MBR_FOLLOW_EN
            if (allowRedir && lba != 0) redir = 1;
            else                        code  = 4;
`else
            code = 4;
`endif
        end
        else if (le(s, 11, 2) != 512)     code = 2;
        else if (s[16] == 0 || s[13] == 0) code = 3;
    endfunction

    task automatic conclude(input logic [7:0] s [512], input int code);
        eBusy = 0;
        if (code != 0) begin
            eErr  = 1;
            eCode = 3'(code);
        end else begin
            eValid = 1;
            eRsvd  = le(s, 14, 2);
            eSpc   = le(s, 13, 1);
            eFats  = le(s, 16, 1);
            eFatSz = le(s, 36, 4);
            eRoot  = le(s, 44, 4);
            ePstart = eSector;
        end
    endtask

    task automatic fill_bpb(input logic [7:0] jmp, input logic [15:0] bps, input logic [7:0] spc,
                            input logic [15:0] rsvd, input logic [7:0] fats, input logic [31:0] fatsz,
                            input logic [31:0] root, input logic [7:0] sigHi);
        for (int i = 0; i < 512; i++) sec[i] = 8'(i*37 + 11);
        sec[0] = jmp; sec[11] = bps[7:0]; sec[12] = bps[15:8]; sec[13] = spc;
        sec[14] = rsvd[7:0]; sec[15] = rsvd[15:8]; sec[16] = fats;
        for (int k = 0; k < 4; k++) begin
            sec[36+k] = fatsz[8*k +: 8];
            sec[44+k] = root[8*k +: 8];
        end
        sec[510] = 8'h55; sec[511] = sigHi;
    endtask

    task automatic fill_mbr(input logic [7:0] b0, input logic [31:0] lba);
        for (int i = 0; i < 512; i++) sec[i] = 8'(i*37 + 11);
        sec[0] = b0;
        for (int k = 0; k < 4; k++) sec['h1C6+k] = lba[8*k +: 8];
        sec[510] = 8'h55; sec[511] = 8'hAA;
    endtask

    task automatic stream(input bit use2, input bit gaps, input bit midStart, input int rstAt,
                          output bit aborted);
        aborted = 0;
        for (int i = 0; i < 512; i++) begin
            if (gaps) begin
                int g = int'($urandom_range(0, 3));
                repeat (g) begin
                    @(negedge updateClock);
                    bus.dataValid = 0; bus.dataByte = 8'($urandom); start = 0;
                end
            end
            @(negedge updateClock);
            if (i == rstAt) begin
                rstn = 0; bus.dataValid = 0; start = 0;
                zero_exp();
                @(negedge updateClock);
                rstn = 1;
                for (int j = i; j < 512; j++) begin
                    @(negedge updateClock);
                    bus.dataValid = 1; bus.dataByte = sec[j];
                end
                @(negedge updateClock);
                bus.dataValid = 0;
                aborted = 1;
                return;
            end
            bus.dataValid = 1;
            bus.dataByte  = use2 ? sec2[i] : sec[i];
            start         = midStart && (i == 200);
        end
    endtask

    task automatic run_parse(input bit gaps, input bit midStart, input bit junk, input int rstAt);
        int code, code2;
        bit redir, redir2, ab;
        logic [31:0] lba, lba2;
        model(sec, 1, code, redir, lba);
        @(negedge updateClock);
        start = 1; bus.dataValid = 0;
        eBusy = 1; eReq = 1; eValid = 0; eErr = 0; eCode = 0; eSector = 32'd0;
        @(negedge updateClock);
        start = 0; bus.dataValid = junk; bus.dataByte = 8'hFF; eReq = 0;
        stream(0, gaps, midStart, rstAt, ab);
        if (ab) return;
        @(negedge updateClock);
        bus.dataValid = 0; start = 0;
        if (redir) begin
            eReq = 1; eSector = lba;
            @(negedge updateClock);
            eReq = 0;
            stream(1, gaps, 0, -1, ab);
            @(negedge updateClock);
            bus.dataValid = 0;
            model(sec2, 0, code2, redir2, lba2);
            conclude(sec2, code2);
        end else begin
            conclude(sec, code);
        end
        repeat (2) @(negedge updateClock);
    endtask

    initial begin
        int p0;
        rstn = 0; start = 0; bus.dataValid = 0; bus.dataByte = 0;
        zero_exp();
        fork
            forever begin
                @(posedge updateClock);
                #1;
                if (bus.readRequest === 1'b1) reqPulses++;
                if (cmpEn) compare_all();
            end
        join_none
        repeat (2) @(negedge updateClock);
        cmpEn = 1;
        @(negedge updateClock);
        rstn = 1;
        repeat (2) @(negedge updateClock);

        // Reference sector
        fill_bpb(8'hEB, 16'h0200, 8'h08, 16'h0020, 8'h02, 32'h0000_03C1, 32'h2, 8'hAA);
        run_parse(0, 0, 0, -1);
        chk("lit_valid", 32'(bpbValid), 32'd1);
        chk("lit_rsvd", 32'(ReservedSectors), 32'h20);
        chk("lit_fats", 32'(NumberOfFAT), 32'd2);
        chk("lit_fatsz", theLengthOfFAT, 32'h3C1);
        chk("lit_root", RootCluster, 32'd2);
        chk("lit_pstart", partitionStart, 32'd0);

        fill_bpb(8'hEB, 16'h0200, 8'h08, 16'h0020, 8'h02, 32'h0000_03C1, 32'h2, 8'h00);
        run_parse(0, 0, 0, -1);
        chk("lit_sig_code", 32'(errorCode), 32'd1);
        chk("lit_sig_keep", 32'(ReservedSectors), 32'h20);

        fill_bpb(8'h33, 16'h0200, 8'h08, 16'h0020, 8'h02, 32'h3C1, 32'h2, 8'h00);
        run_parse(0, 0, 0, -1);
        fill_bpb(8'hEB, 16'h0400, 8'h08, 16'h0020, 8'h02, 32'h3C1, 32'h2, 8'hAA);
        run_parse(0, 0, 0, -1);
        chk("lit_bps_code", 32'(errorCode), 32'd2);
        fill_bpb(8'hEB, 16'h0200, 8'h08, 16'h0020, 8'h00, 32'h3C1, 32'h2, 8'hAA);
        run_parse(0, 0, 0, -1);
        chk("lit_fats_code", 32'(errorCode), 32'd3);
        fill_bpb(8'hEB, 16'h0200, 8'h00, 16'h0020, 8'h02, 32'h3C1, 32'h2, 8'hAA);
        run_parse(0, 0, 0, -1);

        fill_bpb(8'hE9, 16'h0200, 8'h40, 16'h1234, 8'h01, 32'h0001_2345, 32'h0000_ABCD, 8'hAA);
        run_parse(0, 0, 0, -1);
        chk("lit_e9_fatsz", theLengthOfFAT, 32'h0001_2345);

        // MBR at LBA 0 pointing at 0x2000, followed by the reference BPB
        fill_bpb(8'hEB, 16'h0200, 8'h08, 16'h0020, 8'h02, 32'h0000_03C1, 32'h2, 8'hAA);
        sec2 = sec;
        fill_mbr(8'h33, 32'h0000_2000);
        p0 = reqPulses;
        run_parse(0, 0, 0, -1);
`ifdef FAT32_MBR_FOLLOW_EN
        chk("lit_mbr_pulses", 32'(reqPulses - p0), 32'd2);
        chk("lit_mbr_pstart", partitionStart, 32'h2000);
        chk("lit_mbr_sector", bus.readSector, 32'h2000);
`else
        chk("lit_mbr_pulses", 32'(reqPulses - p0), 32'd1);
        chk("lit_mbr_code", 32'(errorCode), 32'd4);
`endif
        fill_mbr(8'h33, 32'd0);
        run_parse(0, 0, 0, -1);
        chk("lit_mbr0_code", 32'(errorCode), 32'd4);

        // Gappy stream, stray start mid-sector, stray dataValid during the request cycle
        fill_bpb(8'hEB, 16'h0200, 8'h08, 16'h0020, 8'h02, 32'h0000_03C1, 32'h2, 8'hAA);
        run_parse(1, 1, 1, -1);
        chk("lit_gap_fatsz", theLengthOfFAT, 32'h3C1);
        chk("lit_gap_pstart", partitionStart, 32'd0);

        // Reset mid-sector, then a fresh parse
        run_parse(0, 0, 0, 100);
        chk("lit_rst_rsvd", 32'(ReservedSectors), 32'd0);
        repeat (3) @(negedge updateClock);
        run_parse(0, 0, 0, -1);
        chk("lit_fresh_rsvd", 32'(ReservedSectors), 32'h20);
        chk("lit_fresh_valid", 32'(bpbValid), 32'd1);

        repeat (3) @(negedge updateClock);
        cmpEn = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fat32_bpb_parser.md
# fat32_bpb_parser

Parses the FAT32 boot sector (BPB) from the SD-card sector byte stream and publishes the volume geometry that root-directory address calculation and file-entry generation depend on. It sits between the SD-card sector reader and the root-directory sector calculator. It issues a read request for the boot sector, captures the BPB fields little-endian as bytes stream in, validates them, and raises a ready flag.

## Interface
Parameters:
- SECTOR_BYTES, 512, bytes per sector expected from the reader and required in the BPB
- BOOT_LBA, 32'd0, sector requested first

Ports:
- updateClock  in  1  clock
- rstn  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begins a parse
- readRequest  out  1  one-cycle pulse; asks the reader for sector readSector
- readSector  out  32  LBA being requested
- dataValid  in  1  qualifies dataByte
- dataByte  in  8  sector byte; byte 0 first, 512 bytes per sector
- ReservedSectors  out  16  BPB offset 0x0E
- SectorsPerCluster  out  8  BPB offset 0x0D
- NumberOfFAT  out  9  BPB offset 0x10, zero-extended
- theLengthOfFAT  out  32  BPB offset 0x24 (FATSz32)
- RootCluster  out  32  BPB offset 0x2C
- partitionStart  out  32  LBA of the parsed boot sector
- busy  out  1  high from the accepted start until DONE or ERR
- bpbValid  out  1  level; published fields are valid
- bpbError  out  1  level; last parse failed
- errorCode  out  3  1=no 0x55AA signature, 2=bytes/sector≠SECTOR_BYTES, 3=zero FAT count or zero sectors/cluster, 4=not a boot sector

## Operation
- States: IDLE, REQ, RECV, CHECK, DONE, ERR.
- IDLE/DONE/ERR + start: go to REQ, clear bpbValid/bpbError, readSector=BOOT_LBA. start is ignored while busy.
- REQ: readRequest=1 for exactly one cycle, clear the 9-bit byte counter, go to RECV.
- RECV: each cycle with dataValid, capture dataByte into the shadow register selected by the counter, then increment. Multi-byte fields are little-endian: byte at offset k goes to bits [8(k-base)+7 : 8(k-base)]. Also capture byte 0 (jump), bytes 0x1FE/0x1FF (signature), and MBR bytes 0x1C6..0x1C9 (partition-1 LBA). When the byte at count 511 is accepted, go to CHECK.
- CHECK (one cycle), in priority order:
  - Signature ≠ 55h,AAh: errorCode 1.
  - Byte 0 not EBh/E9h: errorCode 4 (see Configuration).
  - BytesPerSector ≠ SECTOR_BYTES: errorCode 2.
  - NumberOfFAT = 0 or SectorsPerCluster = 0: errorCode 3.
  - Otherwise: copy the shadow registers to the outputs, partitionStart = readSector, go to DONE.
- DONE: bpbValid=1. ERR: bpbError=1. Both states hold until the next start. Published outputs keep their previous values on error.
- dataValid outside RECV is ignored.

## Timing
- Reset: state IDLE; all outputs 0, including readSector, errorCode, busy, bpbValid, bpbError; counter 0; shadow registers 0.
- start at cycle T: readRequest high at T+1; busy high from T+1.
- Last byte accepted at cycle L: CHECK at L+1. Outputs, bpbValid or bpbError, and busy low are all visible at L+2.
- Back-pressure-free stream: dataValid may have gaps of any length; the counter advances only on dataValid.
- Reset asserted in any state: returns to IDLE on the next edge and discards partial captures. A sector that is still streaming after reset is ignored.

## Configuration
- FAT32_MBR_FOLLOW_EN defined: in CHECK, a valid signature with byte 0 not EBh/E9h is treated as an MBR. The block sets readSector = partition-1 LBA and returns to REQ (second readRequest pulse). The second sector is parsed normally; a non-boot second sector gives errorCode 4. A zero partition LBA also gives errorCode 4. Only one redirection is allowed per start.
- Not defined: the MBR capture registers are absent; byte 0 not EBh/E9h → ERR, errorCode 4, and no second request is issued.

## Test plan
- Valid BPB at LBA 0 (EB, bps=0200h, spc=08h, rsvd=0020h, fats=02h, FATSz32=000003C1h, root=00000002h, 55AA) → bpbValid=1, ReservedSectors=0x0020, NumberOfFAT=2, theLengthOfFAT=0x3C1, RootCluster=2, partitionStart=0, exactly 2 cycles after the last byte.
- Same sector with byte 0x1FF=0x00 → bpbError=1, errorCode=1, outputs unchanged from the previous run.
- bps=0400h → errorCode=2. fats=00h → errorCode=3.
- With FAT32_MBR_FOLLOW_EN: MBR at LBA 0 (byte 0=33h, 0x1C6..9=00 20 00 00) then valid BPB → two readRequest pulses, readSector=0x2000, partitionStart=0x2000, bpbValid=1. Without the macro: errorCode=4 and one pulse only.
- Random dataValid gaps, plus start pulsed mid-RECV → start ignored, the parse result is identical to the gap-free case.
- rstn low at byte 100 → all outputs 0. A fresh start then parses correctly.
